shift_rx4: RTL and testbench

SHIFT_RX4 -- requirements
Module: shift_rx4

---
 rtl/shift_rx4.sv | 102 ++++++++++
 tb/tb_shift_rx4.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/shift_rx4.sv
// shift_rx4: 4-bit LSB-first serial frame receiver with stop/parity error and overrun flags.
// Ports:
//   clk   - system clock, rising edge active
//   rst   - asynchronous active-low reset
//   en    - bit strobe; SI is sampled only on edges where en=1
//   SI    - serial line: start(1), d0..d3, [parity], stop(0)
//   ack   - consumer acknowledge of the word on Q
//   Q     - last received word, d0 in Q[0]
//   valid - Q holds an unacknowledged word
//   busy  - a frame is in progress
//   ferr  - last frame had a bad stop bit
//   perr  - last frame had a parity mismatch (0 unless PARITY_EN)
//   ovr   - sticky overrun, cleared by ack
// Build option: define PARITY_EN to add an even-parity bit between d3 and stop.
module shift_rx4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       SI,
  input  logic       ack,
  output logic [3:0] Q,
  output logic       valid,
  output logic       busy,
  output logic       ferr,
  output logic       perr,
  output logic       ovr
);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`ifdef PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t     state_q;
  logic [1:0] cnt_q;
  logic [3:0] sr_q;
  logic [3:0] q_q;
  logic       par_q;
  logic       valid_q;
  logic       ferr_q;
  logic       perr_q;
  logic       ovr_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      sr_q    <= 4'd0;
      q_q     <= 4'd0;
      par_q   <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      // ack acts independently of the bit strobe; a good stop below overrides the valid clear
      if (ack && valid_q) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
      if (en) begin
        case (state_q)
          IDLE: if (SI) begin
            state_q <= DATA;
            cnt_q   <= 2'd0;
            par_q   <= 1'b0;
          end
          DATA: begin
            sr_q    <= {SI, sr_q[3:1]};
            cnt_q   <= cnt_q + 2'd1;
            par_q   <= par_q ^ SI;
            state_q <= (cnt_q == 2'd3) ? AFTER_DATA : DATA;
          end
          PARITY: begin
            par_q   <= par_q ^ SI;
            state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (SI) ferr_q <= 1'b1;
            else begin
              q_q     <= sr_q;
              valid_q <= 1'b1;
              ferr_q  <= 1'b0;
              // a word still pending and not being acked on this edge is lost
              ovr_q   <= ack ? 1'b0 : (ovr_q | valid_q);
`ifdef PARITY_EN
              perr_q  <= par_q;
`endif
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign Q     = q_q;
  assign valid = valid_q;
  assign busy  = (state_q != IDLE);
  assign ferr  = ferr_q;
  assign perr  = perr_q;
  assign ovr   = ovr_q;
endmodule

// File: tb/tb_shift_rx4.sv
// tb_shift_rx4: scoreboard bench for shift_rx4; frame ends are checked by a monitor against queued expectations.
module tb_shift_rx4;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       SI = 1'b0;
  logic       ack = 1'b0;
  logic [3:0] Q;
  logic       valid, busy, ferr, perr, ovr;
  int         checks = 0;
  int         failures = 0;
  typedef struct {
    logic [3:0] q;
    logic       valid;
    logic       ferr;
    logic       perr;
    logic       ovr;
  } exp_t;
  exp_t       exp_q[$];
  logic [3:0] m_q;
  logic       m_valid, m_ferr, m_perr, m_ovr;
  shift_rx4 dut (
    .clk(clk), .rst(rst), .en(en), .SI(SI), .ack(ack),
    .Q(Q), .valid(valid), .busy(busy), .ferr(ferr), .perr(perr), .ovr(ovr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, want);
    end
  endtask
  task automatic chk_all(input string tag);
    chk({tag, "_Q"}, Q, m_q);
    chk({tag, "_valid"}, {3'b0, valid}, {3'b0, m_valid});
    chk({tag, "_ferr"}, {3'b0, ferr}, {3'b0, m_ferr});
    chk({tag, "_perr"}, {3'b0, perr}, {3'b0, m_perr});
    chk({tag, "_ovr"}, {3'b0, ovr}, {3'b0, m_ovr});
  endtask
  task automatic strobe(input logic b, input logic a = 1'b0);
    SI  = b;
    en  = 1'b1;
    ack = a;
    @(posedge clk); #1;
    en  = 1'b0;
    ack = 1'b0;
    SI  = ~b;
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    #2;
    m_q = 4'd0; m_valid = 0; m_ferr = 0; m_perr = 0; m_ovr = 0;
    chk_all("reset");
    chk("reset_busy", {3'b0, busy}, 4'd0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask
  task automatic send_frame(input logic [3:0] d, input logic stop_ok, input logic par_ok = 1'b1,
                            input logic ack_at_stop = 1'b0);
    exp_t e;
    strobe(1'b1);
    chk("busy_in_frame", {3'b0, busy}, 4'd1);
    for (int i = 0; i < 4; i++) strobe(d[i]);
`ifdef PARITY_EN
    strobe(par_ok ? ^d : ~^d);
`endif
    if (stop_ok) begin
      m_ovr   = ack_at_stop ? 1'b0 : (m_ovr | m_valid);
      m_q     = d;
      m_valid = 1'b1;
      m_ferr  = 1'b0;
`ifdef PARITY_EN
      m_perr  = ~par_ok;
`endif
    end else begin
      m_ferr = 1'b1;
      if (ack_at_stop && m_valid) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
    end
    e = '{q: m_q, valid: m_valid, ferr: m_ferr, perr: m_perr, ovr: m_ovr};
    exp_q.push_back(e);
    strobe(stop_ok ? 1'b0 : 1'b1, ack_at_stop);
  endtask
  task automatic do_ack();
    ack = 1'b1;
    en  = 1'b1;
    SI  = 1'b0;
    @(posedge clk); #1;
    ack = 1'b0;
    en  = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    chk_all("after_ack");
  endtask
  initial begin : monitor
    logic busy_prev;
    exp_t e;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) busy_prev = 1'b0;
      else begin
        if (busy_prev && !busy) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL frame_end_unexpected actual=frame_end expected=none");
          end else begin
            e = exp_q.pop_front();
            chk("frame_Q", Q, e.q);
            chk("frame_valid", {3'b0, valid}, {3'b0, e.valid});
            chk("frame_ferr", {3'b0, ferr}, {3'b0, e.ferr});
            chk("frame_perr", {3'b0, perr}, {3'b0, e.perr});
            chk("frame_ovr", {3'b0, ovr}, {3'b0, e.ovr});
          end
        end
        busy_prev = busy;
      end
    end
  end
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end
  initial begin
    do_reset();
    for (int i = 0; i < 10; i++) strobe(1'b0);
    chk_all("idle");
    chk("idle_busy", {3'b0, busy}, 4'd0);
    send_frame(4'b1011, 1'b1);
    do_ack();
    send_frame(4'b0110, 1'b0);
    send_frame(4'b0110, 1'b1);
    do_ack();
    send_frame(4'b0111, 1'b1);
    send_frame(4'b1110, 1'b1);
    do_ack();
    send_frame(4'b0101, 1'b1);
    send_frame(4'b1001, 1'b1, 1'b1, 1'b1);
    do_ack();
    strobe(1'b1);
    strobe(1'b1);
    strobe(1'b0);
    chk("mid_frame_busy", {3'b0, busy}, 4'd1);
    do_reset();
    strobe(1'b0);
    chk("between_frames_busy", {3'b0, busy}, 4'd0);
    send_frame(4'b1101, 1'b1);
    do_ack();
`ifdef PARITY_EN
    send_frame(4'b1101, 1'b1, 1'b1);
    do_ack();
    send_frame(4'b1101, 1'b1, 1'b0);
    do_ack();
`endif
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size() == 0 ? 4'd0 : 4'd1, 4'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
